// File: rtl/msk_aes_pkg.sv
// rtl/msk_aes_pkg.sv - shared GF(2^8) helpers, share interleave index and scheduler state type
package msk_aes_pkg;

  localparam logic [7:0] GF_POLY = 8'h1b;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_e;

  // Bit i of share j of a byte sits at i*d+j inside that byte's 8*d-bit slice.
  function automatic int ilv_idx(input int i, input int j, input int d);
    return i * d + j;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/msk_inv_mc_column.sv
// rtl/msk_inv_mc_column.sv - combinational share-wise InvMixColumns on one masked column
module msk_inv_mc_column
  import msk_aes_pkg::*;
#(
  parameter int d = 2
) (
  input  logic [32*d-1:0] col_i,
  output logic [32*d-1:0] col_o
);

  // InvMC is linear, so each share is transformed on its own and shares never meet.
  for (genvar s = 0; s < d; s++) begin : g_share
    logic [3:0][7:0] a;
    logic [3:0][7:0] m9, mb, md, me;
    logic [3:0][7:0] o;

    for (genvar k = 0; k < 4; k++) begin : g_byte
      for (genvar i = 0; i < 8; i++) begin : g_bit
        assign a[k][i] = col_i[8*d*k + ilv_idx(i, s, d)];
        assign col_o[8*d*k + ilv_idx(i, s, d)] = o[k][i];
      end
      assign m9[k] = gf_mul9(a[k]);
      assign mb[k] = gf_mulb(a[k]);
      assign md[k] = gf_muld(a[k]);
      assign me[k] = gf_mule(a[k]);
    end

    always_comb begin
      o[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      o[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      o[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      o[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
  end

endmodule

// File: rtl/msk_inv_mc_col_sched.sv
// rtl/msk_inv_mc_col_sched.sv - column scheduler for masked InvMixColumns with registered output
module msk_inv_mc_col_sched
  import msk_aes_pkg::*;
#(
  parameter int d = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [32*d-1:0] in_col,
  input  logic            in_last,
  input  logic            in_bypass,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*d-1:0] out_col,
  output logic [1:0]      out_idx,
  output logic            out_last,
  output logic            busy,
  output logic            err
);

  sched_state_e    state_q, state_d;
  logic [1:0]      col_cnt_q, col_cnt_d;
  logic            bypass_q, bypass_d;
  logic            out_valid_q, out_valid_d;
  logic [32*d-1:0] out_col_q, out_col_d;
  logic [1:0]      out_idx_q, out_idx_d;
  logic            out_last_q, out_last_d;
  logic            err_q, err_d;

  logic [32*d-1:0] mc_col;
  logic            accept;
  logic            eff_bypass;
  logic            at_col3;

  msk_inv_mc_column #(.d(d)) u_column (
    .col_i (in_col),
    .col_o (mc_col)
  );

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign at_col3    = (col_cnt_q == 2'd3);
  // The bypass choice is latched on column 0 and applies to the rest of the state.
  assign eff_bypass = (col_cnt_q == 2'd0) ? in_bypass : bypass_q;

  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    bypass_d    = bypass_q;
    out_valid_d = out_valid_q;
    out_col_d   = out_col_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    err_d       = err_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_col_d   = eff_bypass ? in_col : mc_col;
      out_idx_d   = col_cnt_q;
      out_last_d  = at_col3;
      if ((in_last && !at_col3) || (at_col3 && !in_last)) begin
        err_d = 1'b1;
      end
      // A lone in_last in IDLE keeps the counter at 0; in RUN the count always advances.
      if (state_q == ST_IDLE) begin
        bypass_d  = in_bypass;
        col_cnt_d = in_last ? 2'd0 : 2'd1;
      end else begin
        col_cnt_d = at_col3 ? 2'd0 : col_cnt_q + 2'd1;
      end
      state_d = (col_cnt_d == 2'd0) ? ST_IDLE : ST_RUN;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_cnt_q   <= 2'd0;
      bypass_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_idx_q   <= 2'd0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      bypass_q    <= bypass_d;
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_col   = out_col_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign err       = err_q;
  assign busy      = (col_cnt_q != 2'd0) || out_valid_q;

endmodule
